// File: rtl/ins_seq_rv32i_r_pkg.sv
// Shared RV32I R-type constants, ALU op encoding, sequencer states and field layout.
package rv32i_pkg;

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
        ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
        ALU_OR   = 4'd8, ALU_AND = 4'd9
    } alu_op_t;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_TRAP
    } seq_state_t;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] op;
    } rtype_t;

    // Only meaningful for legal encodings; funct7 just selects the alternate op.
    function automatic alu_op_t alu_map(input logic [2:0] f3, input logic [6:0] f7);
        case (f3)
            F3_ADD_SUB: alu_map = (f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            F3_SLL:     alu_map = ALU_SLL;
            F3_SLT:     alu_map = ALU_SLT;
            F3_SLTU:    alu_map = ALU_SLTU;
            F3_XOR:     alu_map = ALU_XOR;
            F3_SRL_SRA: alu_map = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            F3_OR:      alu_map = ALU_OR;
            default:    alu_map = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/ins_seq_rv32i_r_if.sv
// Sequencer-facing bundle: run control, fetch port, regfile port, ALU port and status.
interface ins_seq_rv32i_r_if;
    import rv32i_pkg::*;

    logic        run;
    logic        ins_req;
    logic [31:0] ins_addr;
    logic        ins_ack;
    logic [31:0] ins_data;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    alu_op_t     alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;
    logic        illegal;
    logic [31:0] trap_pc;
    logic [31:0] instret;

    modport master (
        input  run, ins_ack, ins_data, rf_rdata1, rf_rdata2, alu_result,
        output ins_req, ins_addr, rf_raddr1, rf_raddr2, alu_op, alu_a, alu_b,
               rf_we, rf_waddr, rf_wdata, busy, illegal, trap_pc, instret
    );

    modport slave (
        output run, ins_ack, ins_data, rf_rdata1, rf_rdata2, alu_result,
        input  ins_req, ins_addr, rf_raddr1, rf_raddr2, alu_op, alu_a, alu_b,
               rf_we, rf_waddr, rf_wdata, busy, illegal, trap_pc, instret
    );

endinterface

// File: rtl/ins_seq_rv32i_r_dec.sv
// R-type field decoder: splits a 32-bit instruction word into its fields.
module ins_seq_rv32i_r_dec
    import rv32i_pkg::*;
(
    input  logic [31:0] i_ins,
    output rtype_t      o_fields
);

    assign o_fields.op     = i_ins[6:0];
    assign o_fields.rd     = i_ins[11:7];
    assign o_fields.funct3 = i_ins[14:12];
    assign o_fields.rs1    = i_ins[19:15];
    assign o_fields.rs2    = i_ins[24:20];
    assign o_fields.funct7 = i_ins[31:25];

endmodule

// File: rtl/ins_seq_rv32i_r.sv
// Multi-cycle control FSM for RV32I R-type: FETCH -> DECODE -> EXEC -> WB, TRAP on illegal.
module ins_seq_rv32i_r
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input logic               clk,
    input logic               rst_n,
    ins_seq_rv32i_r_if.master bus
);

    seq_state_t  r_state, w_next;
    logic [31:0] r_pc, r_ins, r_wdata, r_instret, r_trap_pc;
    logic        r_illegal;
    rtype_t      w_f;
    logic        w_legal;
    alu_op_t     w_alu_op;

    ins_seq_rv32i_r_dec u_dec (.i_ins(r_ins), .o_fields(w_f));

    // Alternate funct7 is only defined for SUB and SRA.
    assign w_legal = (w_f.op == OPC_OP) &&
                     ((w_f.funct7 == F7_BASE) ||
                      ((w_f.funct7 == F7_ALT) &&
                       ((w_f.funct3 == F3_ADD_SUB) || (w_f.funct3 == F3_SRL_SRA))));
    assign w_alu_op = alu_map(w_f.funct3, w_f.funct7);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.run)     w_next = S_FETCH;
            S_FETCH:  if (bus.ins_ack) w_next = S_DECODE;
            S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
            S_EXEC:   w_next = S_WB;
            S_WB:     w_next = bus.run ? S_FETCH : S_IDLE;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_ins     <= '0;
            r_wdata   <= '0;
            r_instret <= '0;
            r_illegal <= 1'b0;
            r_trap_pc <= '0;
        end else begin
            if (r_state == S_FETCH && bus.ins_ack) r_ins <= bus.ins_data;
            if (r_state == S_EXEC) r_wdata <= bus.alu_result;
            if (r_state == S_WB) begin
                r_pc      <= r_pc + PC_STEP;
                r_instret <= r_instret + 32'd1;
            end
            if (r_state == S_DECODE && !w_legal) begin
                r_illegal <= 1'b1;
                r_trap_pc <= r_pc;
            end
        end
    end

    always_comb begin
        bus.ins_req   = 1'b0;
        bus.ins_addr  = r_pc;
        bus.rf_raddr1 = '0;
        bus.rf_raddr2 = '0;
        bus.alu_op    = ALU_ADD;
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        bus.rf_we     = 1'b0;
        bus.rf_waddr  = '0;
        bus.rf_wdata  = '0;
        bus.busy      = (r_state != S_IDLE) && (r_state != S_TRAP);
        bus.illegal   = r_illegal;
        bus.trap_pc   = r_trap_pc;
        bus.instret   = r_instret;
        case (r_state)
            S_FETCH:  bus.ins_req = 1'b1;
            S_DECODE: begin
                bus.rf_raddr1 = w_f.rs1;
                bus.rf_raddr2 = w_f.rs2;
            end
            S_EXEC: begin
                bus.rf_raddr1 = w_f.rs1;
                bus.rf_raddr2 = w_f.rs2;
                bus.alu_op    = w_alu_op;
                bus.alu_a     = bus.rf_rdata1;
                bus.alu_b     = bus.rf_rdata2;
            end
            S_WB: begin
                bus.rf_we    = (w_f.rd != 5'd0);
                bus.rf_waddr = w_f.rd;
                bus.rf_wdata = r_wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ins_seq_rv32i_r.sv
// Directed bench: per-cycle expected outputs queued by the driver, checked on the falling edge.
module tb_ins_seq_rv32i_r;
    import rv32i_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ins_seq_rv32i_r_if bus ();

    ins_seq_rv32i_r #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        logic        req;  logic [31:0] addr; logic busy;
        logic        we;   logic [4:0]  waddr; logic [31:0] wdata; logic chk_wb;
        logic [3:0]  aop;  logic [31:0] a; logic [31:0] b;
        logic        chk_rd; logic [4:0] ra1; logic [4:0] ra2;
        logic        ill;  logic [31:0] tpc; logic [31:0] iret;
    } exp_t;

    exp_t expq[$];
    int n_cmp = 0;
    int n_bad = 0;

    // architectural model state
    logic [31:0] m_pc = 0, m_instret = 0, m_tpc = 0;
    logic        m_ill = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h want %h", n, $time, act, want);
        end
    endtask

    function automatic logic legal(input logic [31:0] i);
        return (i[6:0] == 7'b0110011) &&
               ((i[31:25] == 7'b0) ||
                ((i[31:25] == 7'b0100000) && ((i[14:12] == 3'd0) || (i[14:12] == 3'd5))));
    endfunction

    function automatic logic [3:0] amap(input logic [31:0] i);
        case (i[14:12])
            3'd0: return i[30] ? 4'd1 : 4'd0;
            3'd1: return 4'd2;
            3'd2: return 4'd3;
            3'd3: return 4'd4;
            3'd4: return 4'd5;
            3'd5: return i[30] ? 4'd7 : 4'd6;
            3'd6: return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    function automatic exp_t base();
        exp_t e;
        e = '{default: '0};
        e.addr = m_pc; e.iret = m_instret; e.ill = m_ill; e.tpc = m_tpc;
        return e;
    endfunction

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("ins_req", bus.ins_req, e.req);
            chk("ins_addr", bus.ins_addr, e.addr);
            chk("busy", bus.busy, e.busy);
            chk("rf_we", bus.rf_we, e.we);
            chk("alu_op", bus.alu_op, e.aop);
            chk("alu_a", bus.alu_a, e.a);
            chk("alu_b", bus.alu_b, e.b);
            chk("illegal", bus.illegal, e.ill);
            chk("trap_pc", bus.trap_pc, e.tpc);
            chk("instret", bus.instret, e.iret);
            if (e.chk_rd) begin
                chk("rf_raddr1", bus.rf_raddr1, e.ra1);
                chk("rf_raddr2", bus.rf_raddr2, e.ra2);
            end
            if (e.chk_wb) begin
                chk("rf_waddr", bus.rf_waddr, e.waddr);
                chk("rf_wdata", bus.rf_wdata, e.wdata);
            end
        end
    end

    // Queue what the outputs must be after the next rising edge, then move past its checking edge.
    task automatic step(input exp_t e);
        expq.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_pc = 0; m_instret = 0; m_ill = 0; m_tpc = 0;
        step(base());
        rst_n = 1'b1;
    endtask

    task automatic fetch_from_idle();
        exp_t e;
        bus.run = 1'b1;
        e = base(); e.req = 1; e.busy = 1;
        step(e);
    endtask

    task automatic decode_step(input logic [31:0] ins);
        exp_t e;
        bus.ins_ack = 1'b1; bus.ins_data = ins;
        e = base(); e.busy = 1; e.chk_rd = 1; e.ra1 = ins[19:15]; e.ra2 = ins[24:20];
        step(e);
        bus.ins_ack = 1'b0;
    endtask

    // Entered with the DUT in FETCH; leaves it in FETCH, IDLE or TRAP.
    task automatic run_ins(input logic [31:0] ins, input int w, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] res,
                           input logic run_next, input logic [3:0] pin_op);
        exp_t e;
        for (int i = 0; i < w; i++) begin
            bus.ins_ack = 1'b0;
            e = base(); e.req = 1; e.busy = 1;
            step(e);
        end
        decode_step(ins);
        if (!legal(ins)) begin
            m_ill = 1; m_tpc = m_pc;
            step(base());
            return;
        end
        bus.rf_rdata1 = r1; bus.rf_rdata2 = r2; bus.alu_result = res;
        e = base(); e.busy = 1; e.chk_rd = 1; e.ra1 = ins[19:15]; e.ra2 = ins[24:20];
        e.aop = amap(ins); e.a = r1; e.b = r2;
        step(e);
        if (pin_op != 4'hF) chk("pin_alu_op", bus.alu_op, pin_op);
        bus.run = run_next;
        e = base(); e.busy = 1; e.chk_wb = 1;
        e.we = (ins[11:7] != 5'd0); e.waddr = ins[11:7]; e.wdata = res;
        step(e);
        if (ins == 32'h002081B3) begin
            chk("pin_add_we", bus.rf_we, 1);
            chk("pin_add_waddr", bus.rf_waddr, 3);
            chk("pin_add_wdata", bus.rf_wdata, 12);
        end
        bus.rf_rdata1 = 0; bus.rf_rdata2 = 0; bus.alu_result = 0;
        m_pc = m_pc + 4; m_instret = m_instret + 1;
        e = base();
        if (run_next) begin e.req = 1; e.busy = 1; end
        step(e);
    endtask

    initial begin
        exp_t e;
        bus.run = 0; bus.ins_ack = 0; bus.ins_data = 0;
        bus.rf_rdata1 = 0; bus.rf_rdata2 = 0; bus.alu_result = 0;

        do_reset();
        do_reset();
        step(base());                       // idle, run low
        chk("pin_reset_addr", bus.ins_addr, 32'h0);

        fetch_from_idle();
        run_ins(32'h002081B3, 0, 5, 7, 12, 1'b1, 4'hF);     // add x3,x1,x2
        chk("pin_add_pc", bus.ins_addr, 32'h4);
        chk("pin_add_instret", bus.instret, 1);
        run_ins(32'h40208233, 0, 9, 4, 5, 1'b1, 4'd1);      // sub x4,x1,x2
        run_ins(32'h40209033, 0, 0, 0, 0, 1'b1, 4'hF);      // illegal at pc=8
        chk("pin_trap_pc", bus.trap_pc, 32'h8);
        chk("pin_illegal", bus.illegal, 1);
        bus.ins_ack = 1'b1;                 // TRAP must ignore run and ack
        for (int i = 0; i < 3; i++) step(base());
        bus.ins_ack = 1'b0;
        chk("pin_trap_req", bus.ins_req, 0);
        bus.run = 1'b0;
        do_reset();
        chk("pin_reset_illegal", bus.illegal, 0);

        fetch_from_idle();
        run_ins(32'h4020D2B3, 0, 32'hFFFFFFF8, 1, 32'hFFFFFFFC, 1'b1, 4'd7);  // sra x5
        run_ins(32'h00208033, 0, 1, 2, 3, 1'b1, 4'hF);      // add x0: no write
        chk("pin_rd0_pc", bus.ins_addr, 32'h8);
        chk("pin_rd0_instret", bus.instret, 2);
        run_ins(32'h0020C333, 3, 32'hF0, 32'h0F, 32'hFF, 1'b0, 4'd5);  // xor, ack waits, run dropped
        step(base());
        chk("pin_idle_req", bus.ins_req, 0);

        fetch_from_idle();
        decode_step(32'h0020E3B3);          // or x7,x1,x2
        bus.rf_rdata1 = 3; bus.rf_rdata2 = 4; bus.alu_result = 7;
        e = base(); e.busy = 1; e.chk_rd = 1; e.ra1 = 5'd1; e.ra2 = 5'd2;
        e.aop = 4'd8; e.a = 3; e.b = 4;
        step(e);
        bus.run = 1'b0; bus.rf_rdata1 = 0; bus.rf_rdata2 = 0; bus.alu_result = 0;
        do_reset();                         // reset mid-EXEC
        chk("pin_rst_pc", bus.ins_addr, 32'h0);
        chk("pin_rst_instret", bus.instret, 0);
        bus.ins_ack = 1'b1; bus.ins_data = 32'h002081B3;
        step(base());
        step(base());
        bus.ins_ack = 1'b0;
        chk("pin_idle_busy", bus.busy, 0);

        @(negedge clk);
        chk("queue_drained", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ins_seq_rv32i_r.md
Name: ins_seq_rv32i_r

Overview:
Multi-cycle sequencer for RV32I R-type (OP, opcode 7'b0110011) execution.
- Fetches a 32-bit instruction over a req/ack port and decodes it into fields (op, funct3, funct7, rs1, rs2, rd).
- Validates the field combination, reads the register file, issues an ALU op, writes back rd and advances the PC.
- Sits between instruction memory, the register file and the ALU as the core's control FSM for the R-type subset.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 32'd4, PC increment per retired instruction

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous reset, active low
run  in  1  start/continue enable
ins_req  out  1  instruction fetch request
ins_addr  out  32  fetch address (current PC)
ins_ack  in  1  fetch data valid this cycle
ins_data  in  32  fetched instruction
rf_raddr1  out  5  regfile read address 1 (rs1)
rf_raddr2  out  5  regfile read address 2 (rs2)
rf_rdata1  in  32  read data 1, valid one cycle after address
rf_rdata2  in  32  read data 2, valid one cycle after address
alu_op  out  4  ALU operation code (package enum)
alu_a  out  32  ALU operand A
alu_b  out  32  ALU operand B
alu_result  in  32  combinational ALU result
rf_we  out  1  regfile write enable
rf_waddr  out  5  write address (rd)
rf_wdata  out  32  write data
busy  out  1  high in any state except IDLE and TRAP
illegal  out  1  sticky illegal-instruction flag
trap_pc  out  32  PC of the faulting instruction
instret  out  32  retired-instruction counter, wraps modulo 2^32

Behaviour:
- Reset (rst_n low at a rising edge): state=IDLE, pc=RESET_PC, instret=0, illegal=0, trap_pc=0, latched instruction=0. All other outputs are 0; ins_addr=pc.
- IDLE:
  - ins_req=0, and ins_ack is ignored.
  - run=1 -> FETCH.
- FETCH:
  - ins_req=1 and ins_addr=pc, held stable until ins_ack.
  - On ins_ack, latch ins_data -> DECODE.
  - An ack in the same cycle as req is legal.
- DECODE:
  - rf_raddr1/2 are driven from the latched rs1/rs2.
  - Legal means op==7'b0110011 and either funct7==7'b0000000, or funct7==7'b0100000 with funct3 in {000, 101}.
  - Illegal -> TRAP: set illegal=1 and trap_pc=pc; no write, no PC advance, no instret increment.
  - Legal -> EXEC.
- EXEC:
  - alu_a=rf_rdata1, alu_b=rf_rdata2, alu_op from funct3/funct7.
  - rf_raddr1/2 are held.
  - alu_result is registered into the wdata register -> WB.
- WB:
  - rf_we=1 only if rd!=0; rf_waddr=rd, rf_wdata=registered result.
  - pc+=PC_STEP (32-bit wrap), instret+=1.
  - Next state: run=1 -> FETCH, run=0 -> IDLE.
- TRAP: terminal; only reset exits. busy=0.
- run dropped mid-instruction: the current instruction completes through WB, then IDLE.
- Outside EXEC, alu_* are held at 0. Outside WB, rf_we=0.
- Throughput: 4 cycles per instruction with zero-wait ack (FETCH, DECODE, EXEC, WB).
- Reset mid-fetch: ins_req=0 from the reset edge. A late ack is ignored because the FSM is in IDLE.

Decomposition:
- Package rv32i_pkg:
  - OPC_OP=7'b0110011, F7_BASE, F7_ALT
  - funct3 constants
  - enum alu_op_t: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9
  - enum seq_state_t
- Sub-module: the existing R-type field decoder, instantiated on the latched instruction register.
- Legality check and alu_op mapping stay in this block.

Test Plan:
- Sequence: reset, run=1, ins_ack same cycle, ins_data=32'h002081B3 (add x3,x1,x2), rf_rdata1=5, rf_rdata2=7, alu_result=12.
  - WB cycle 4: rf_we=1, rf_waddr=3, rf_wdata=12.
  - After WB: pc=4, instret=1.
- Sub and sra mapping:
  - 32'h40208233 (sub x4,x1,x2) -> alu_op=SUB.
  - 32'h4020D2B3 (sra x5,x1,x2) -> alu_op=SRA.
  - Both retire normally.
- rd=0: 32'h00208033 -> rf_we stays 0, pc still +4, instret increments.
- Illegal: 32'h40209033 (funct7 alt, funct3 001) at pc=8.
  - illegal=1, trap_pc=8, busy=0, no rf_we.
  - ins_req stays 0 until reset; reset clears illegal.
- Fetch wait: ack delayed 3 cycles -> ins_req/ins_addr held constant for 4 cycles.
  - Dropping run during EXEC completes WB, then IDLE with ins_req=0.
- Reset mid-EXEC: rst_n low one edge -> pc=RESET_PC, instret=0, state IDLE.
  - An ack presented in IDLE is ignored: no state change.
